booth_mul_pipe: RTL
===================

Name: booth_mul_pipe

Overview:
- Two-stage pipelined 32x32 multiplier for the EXE/MEM path of the CPU core.
- Stage 1 performs radix-4 Booth encoding of a 33-bit extended multiplier, generates 17 partial products, transposes them into 17-bit columns and registers them.
- Stage 2 compresses every column with the existing 17-input Wallace column slice, chained column-to-column through its 14-bit carry vectors, then performs a final 64-bit carry-propagate add and registers the result.
- Valid/ready handshake on both sides; synchronous flush cancels in-flight operations on exception or ertn.

Parameters:
- TAG_W, 5: width of the side-band tag (destination register number) carried alongside each operation.

Ports:
- clk        input   1      system clock
- reset      input   1      synchronous active-high reset
- flush      input   1      synchronous pipeline cancel
- in_valid   input   1      request valid
- in_ready   output  1      request accepted when in_valid && in_ready
- op         input   2      00 mul.w (low 32), 01 mulh.w (signed high 32), 10 mulh.wu (unsigned high 32), 11 reserved (treated as 00)
- src1       input   32     multiplicand
- src2       input   32     multiplier
- in_tag     input   TAG_W  side-band tag
- out_valid  output  1      result valid
- out_ready  input   1      consumer accepts when out_valid && out_ready
- result     output  32     selected product half
- out_tag    output  TAG_W  tag of the result

Behaviour:
- Extension: for op 01, operands are sign-extended to 33 bits; otherwise they are zero-extended. The product is computed as the exact 66-bit two's-complement value. Bits [63:0] are used.
- Booth: multiplier bits {y32..y0, y-1 = 0}. Group k (k = 0..16) uses y[2k+1], y[2k], y[2k-1] and selects 0, +X, +2X, -X or -2X. Each partial product is 66 bits, sign-extended and shifted left by 2k.
- Negation for PP0..PP15 is one's complement plus correction bit neg[k]. PP16 is formed in true two's complement and has no correction bit.
- Stage 1 register stores:
  - the 66 columns, where column j bit k = PP_k[j];
  - neg[15:0], op, tag, and valid s1_v.
- Stage 2 Wallace chaining:
  - Column 0 Cin = neg[13:0].
  - Column j Cin = column j-1 Cout for j ≥ 1.
  - The top column's Cout is discarded.
- Final add: result64 = S[63:0] + {C[62:0], neg[14]} + neg[15]. Width is truncated to 64 bits.
- Result select: op 00/11 -> result64[31:0]; op 01/10 -> result64[63:32]. Stored in the output register with out_tag; out_valid = s2_v.
- Handshake:
  - s2_go = !s2_v || out_ready.
  - s1_go = s1_v && s2_go.
  - in_ready = (!s1_v || s2_go) && !reset.
  - Stage 1 loads on in_valid && in_ready. Stage 2 loads on s1_go.
  - If the stage-2 slot stalls, both stages hold their contents unchanged.
- Latency: an accepted request appears on out_valid 2 cycles later when there is no backpressure. Throughput is 1 per cycle.
- Stall rule: once asserted, out_valid, result and out_tag stay stable until the handshake completes.
- Simultaneous events:
  - Stage 1 accepts a new request in the same cycle stage 2 advances (full pipelining).
  - out_ready with !out_valid has no effect.
- Flush:
  - s1_v and s2_v clear next cycle.
  - A request presented in the flush cycle is dropped.
  - out_valid is 0 in the cycle after flush.
  - flush takes priority over in_valid and out_ready.
- Reset:
  - s1_v = 0, s2_v = 0, out_valid = 0, result = 0, out_tag = 0.
  - in_ready = 0 while reset is high.
  - Reset mid-operation discards all in-flight operations, identical to flush.
- Data registers need no reset except result and out_tag.

Test Plan:
- op 00, src1 = 0x7FFFFFFF, src2 = 0x7FFFFFFF -> result 0x00000001 two cycles later; op 01 on the same operands -> 0x3FFFFFFF.
- src1 = src2 = 0xFFFFFFFF: op 01 -> 0x00000000; op 10 -> 0xFFFFFFFE; op 00 -> 0x00000001.
- src1 = src2 = 0x80000000: op 01 -> 0x40000000; op 10 -> 0x40000000; op 00 -> 0x00000000.
- Back-to-back stream of 8 ops with tags 0..7 and out_ready = 1 -> 8 consecutive out_valid cycles, in tag order, each correct.
- out_ready held low for 3 cycles while streaming -> in_ready drops after 2 requests are held; result and out_tag are stable; no loss or duplication after release.
- flush asserted with both stages full plus in_valid -> out_valid = 0 next cycle and no result for any of the 3 ops. Then a request with src1 = 3, src2 = -5, op 00 -> result 0xFFFFFFF1.
- Random signed/unsigned regression against the 64-bit reference product, including 0, ±1, 0x80000000 and 0xFFFFFFFF corner operands.

Source files
------------

// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: two-stage pipelined 32x32 multiplier for the EXE/MEM path.
//
// Stage 1: radix-4 Booth encoding of the 33-bit extended multiplier. It
//          builds 17 partial products and transposes them into 17-bit
//          columns, which are registered.
// Stage 2: each column is compressed by a 17-input Wallace slice. The slices
//          are chained column to column through 14-bit carry vectors. A final
//          carry-propagate add follows, and the selected product half is
//          registered.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds its payload stable while
// valid is high and ready is low. ready never depends on valid on the same
// side.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            synchronous cancel of all in-flight operations
//   in_valid/ready   request handshake; op, src1, src2 and in_tag form the payload
//   op               00 mul.w, 01 mulh.w, 10 mulh.wu, 11 treated as 00
//   out_valid/ready  result handshake; result and out_tag form the payload
//   s1_valid, s2_valid  pipeline occupancy (debug visibility)
module booth_mul_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [31:0]      src1,
  input  logic [31:0]      src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag,
  output logic             s1_valid,
  output logic             s2_valid
);

  // Only product bits [63:0] are ever observed. Columns 64/65 of the exact
  // 66-bit sum carry only upward, so every partial product is kept modulo
  // 2^64 and 64 columns are stored.
  localparam int NCOL = 64;

  // Full adder. Returns {carry, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // 17-input Wallace column slice. Returns {cout[13:0], c, s}.
  // The carry inputs enter at later levels than the carries leaving the
  // same level. This keeps the chain between columns free of loops.
  function automatic logic [15:0] wallace17(input logic [16:0] din, input logic [13:0] cin);
    logic [13:0] co;
    logic [4:0]  l1;
    logic [3:0]  l2;
    logic [1:0]  l3, l4, r;
    logic [11:0] v2;
    logic [7:0]  v3;
    logic [5:0]  v4;
    logic [3:0]  v5;
    logic        l5;
    co = '0;
    l1 = '0;
    l2 = '0;
    l3 = '0;
    l4 = '0;
    for (int i = 0; i < 5; i++) begin
      r = fa(din[3*i], din[3*i+1], din[3*i+2]);
      l1[i] = r[0];
      co[i] = r[1];
    end
    v2 = {cin[4:0], din[16:15], l1};
    for (int i = 0; i < 4; i++) begin
      r = fa(v2[3*i], v2[3*i+1], v2[3*i+2]);
      l2[i] = r[0];
      co[5+i] = r[1];
    end
    v3 = {cin[8:5], l2};
    for (int i = 0; i < 2; i++) begin
      r = fa(v3[3*i], v3[3*i+1], v3[3*i+2]);
      l3[i] = r[0];
      co[9+i] = r[1];
    end
    v4 = {cin[10:9], v3[7:6], l3};
    for (int i = 0; i < 2; i++) begin
      r = fa(v4[3*i], v4[3*i+1], v4[3*i+2]);
      l4[i] = r[0];
      co[11+i] = r[1];
    end
    v5 = {cin[12:11], l4};
    r = fa(v5[0], v5[1], v5[2]);
    l5 = r[0];
    co[13] = r[1];
    r = fa(l5, v5[3], cin[13]);
    return {co, r[1], r[0]};
  endfunction

  // Booth select for the triplet {y[2k+1], y[2k], y[2k-1]}.
  // Returns {neg, magnitude}. The magnitude is 0, X or 2X.
  function automatic logic [64:0] booth_sel(input logic [2:0] trip, input logic [63:0] x1);
    case (trip)
      3'b001, 3'b010: return {1'b0, x1};
      3'b011:         return {1'b0, x1 << 1};
      3'b100:         return {1'b1, x1 << 1};
      3'b101, 3'b110: return {1'b1, x1};
      default:        return '0;
    endcase
  endfunction

  // ---------------- stage 1: Booth encode + transpose ----------------
  logic [16:0] col_d [NCOL];
  logic [15:0] neg_d;

  always_comb begin
    logic [32:0] x;
    logic [33:0] y;
    logic [34:0] yb;
    logic [63:0] x1, pp;
    logic [64:0] sel;
    x   = (op == 2'b01) ? {src1[31], src1} : {1'b0, src1};
    y   = (op == 2'b01) ? {{2{src2[31]}}, src2} : {2'b00, src2};
    yb  = {y, 1'b0};                      // yb[i+1] = y[i], yb[0] = y[-1] = 0
    x1  = {{31{x[32]}}, x};
    neg_d = '0;
    for (int j = 0; j < NCOL; j++) col_d[j] = '0;
    // PP0..PP15: complementing the whole shifted value also sets its low 2k
    // zero bits. The +1 correction therefore always lands at weight 1.
    for (int k = 0; k < 16; k++) begin
      sel = booth_sel(yb[2*k +: 3], x1);
      pp  = sel[63:0] << (2*k);
      if (sel[64]) pp = ~pp;
      neg_d[k] = sel[64];
      for (int j = 0; j < NCOL; j++) col_d[j][k] = pp[j];
    end
    // PP16 is negated in true two's complement and needs no correction bit.
    sel = booth_sel(yb[34:32], x1);
    pp  = sel[63:0] << 32;
    if (sel[64]) pp = -pp;
    for (int j = 0; j < NCOL; j++) col_d[j][16] = pp[j];
  end

  logic             s1_v, s2_v;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [15:0]      s1_neg;
  logic [16:0]      s1_col [NCOL];
  logic             s1_go, s2_go, accept;

  assign s2_go    = !s2_v || out_ready;
  assign s1_go    = s1_v && s2_go;
  assign in_ready = (!s1_v || s2_go) && !reset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) s1_v <= 1'b0;
    else if (accept)    s1_v <= 1'b1;
    else if (s1_go)     s1_v <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_col <= col_d;
      s1_neg <= neg_d;
      s1_op  <= op;
      s1_tag <= in_tag;
    end
  end

  // ---------------- stage 2: Wallace chain + final add ----------------
  logic [63:0] sum_v;
  logic [62:0] car_v;
  logic [63:0] res64;
  logic [31:0] res_sel;

  always_comb begin
    logic [13:0] cin;
    logic [15:0] w;
    cin   = s1_neg[13:0];
    sum_v = '0;
    car_v = '0;
    for (int j = 0; j < NCOL; j++) begin
      w = wallace17(s1_col[j], cin);
      sum_v[j] = w[0];
      if (j < 63) car_v[j] = w[1];
      cin = w[15:2];                      // the top column's carry-out is dropped
    end
    res64   = sum_v + {car_v, s1_neg[14]} + {63'd0, s1_neg[15]};
    res_sel = (s1_op == 2'b01 || s1_op == 2'b10) ? res64[63:32] : res64[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_v    <= 1'b0;
      result  <= '0;
      out_tag <= '0;
    end else if (flush) begin
      s2_v <= 1'b0;
    end else if (s1_go) begin
      s2_v    <= 1'b1;
      result  <= res_sel;
      out_tag <= s1_tag;
    end else if (out_ready) begin
      s2_v <= 1'b0;
    end
  end

  assign out_valid = s2_v;
  assign s1_valid  = s1_v;
  assign s2_valid  = s2_v;

endmodule
